// File: rtl/booth_mult_seq.sv
// Sequential signed multiplier using radix-4 (modified) Booth recoding.
//
// A start pulse latches both operands. The next cycle is a load cycle. The
// following STEPS cycles each retire one Booth digit. A one-cycle DONE pulse
// then presents the low word of the product and a signed-overflow flag.
//
// Ports
//   clock          system clock, rising edge
//   reset          synchronous, active-high; clears all state and outputs
//   ctrl_MULT      start pulse; operands sampled on the same edge; aborts any
//                  operation already in flight
//   data_operandA  multiplicand, two's complement
//   data_operandB  multiplier, two's complement
//   product_word   {product[2W-1:0], booth guard bit} for the product register
//   product_we     high while product_word carries a fresh value (load + steps)
//   data_result    low WIDTH bits of the final product, held until next DONE
//   data_exception product does not fit in WIDTH signed bits
//   data_resultRDY one-cycle pulse when data_result/data_exception are valid
//   busy           high during load and step cycles
module booth_mult_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEPS = WIDTH / 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_MULT,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [WIDTH-1:0]   data_operandB,
  output logic [2*WIDTH:0]   product_word,
  output logic               product_we,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_exception,
  output logic               data_resultRDY,
  output logic               busy
);

  // Upper half carries two extra bits so that +/-2M never overflows the adder.
  localparam int unsigned UW = WIDTH + 2;
  localparam int unsigned AW = UW + WIDTH + 1;
  localparam int unsigned CW = $clog2(STEPS + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;

  logic             last_step;

  // Booth datapath
  logic [UW-1:0]    m_ext, m2_ext, addend, sum;
  logic             cin;
  logic [AW-1:0]    shifted;
  logic [2*WIDTH-1:0] prod_next;

  assign last_step = (cnt_q == CW'(STEPS - 1));

  assign m_ext  = {{2{mcand_q[WIDTH-1]}}, mcand_q};
  assign m2_ext = {mcand_q[WIDTH-1], mcand_q, 1'b0};

  // Negative digits invert the operand and inject a carry of one.
  always_comb begin
    addend = '0;
    cin    = 1'b0;
    unique case (acc_q[2:0])
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m2_ext;
      3'b100: begin
        addend = ~m2_ext;
        cin    = 1'b1;
      end
      3'b101, 3'b110: begin
        addend = ~m_ext;
        cin    = 1'b1;
      end
      default:        addend = '0;
    endcase
  end

  assign sum       = acc_q[AW-1 -: UW] + addend + {{(UW-1){1'b0}}, cin};
  // Arithmetic right shift by two of {sum, lower, guard}.
  assign shifted   = {{2{sum[UW-1]}}, sum, acc_q[AW-UW-1:2]};
  assign prod_next = shifted[2*WIDTH:1];

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a start pulse wins from any state.
  always_comb begin
    state_d = state_q;
    if (ctrl_MULT) begin
      state_d = StLoad;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StLoad:  state_d = StRun;
        StRun:   state_d = last_step ? StDone : StRun;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs
  always_comb begin
    product_we     = (state_q == StLoad) || (state_q == StRun);
    busy           = (state_q == StLoad) || (state_q == StRun);
    data_resultRDY = (state_q == StDone);
    product_word   = acc_q[2*WIDTH:0];
    data_result    = result_q;
    data_exception = exc_q;
  end

  // Datapath next-state
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    exc_d    = exc_q;
    if (ctrl_MULT) begin
      mcand_d = data_operandA;
      acc_d   = {{UW{1'b0}}, data_operandB, 1'b0};
      cnt_d   = '0;
    end else if (state_q == StRun) begin
      acc_d = shifted;
      cnt_d = cnt_q + CW'(1);
      if (last_step) begin
        result_d = prod_next[WIDTH-1:0];
        // Overflow unless bits [2W-1:W-1] are a pure sign extension.
        exc_d    = !((&prod_next[2*WIDTH-1:WIDTH-1]) || (~|prod_next[2*WIDTH-1:WIDTH-1]));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [64:0] product_word;
  logic        product_we;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks;
  int failures;

  booth_mult_seq #(
    .WIDTH(32),
    .STEPS(16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_MULT     (ctrl_MULT),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .product_word  (product_word),
    .product_we    (product_we),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse ctrl_MULT over one rising edge, then scramble the operands. Returns
  // at the falling edge of the cycle right after the start edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Count cycles (0 = first cycle after the start edge) until resultRDY.
  task automatic wait_result(output int lat, output int we_cnt);
    lat    = -1;
    we_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (data_resultRDY) begin
        lat = k;
        break;
      end
      if (product_we) we_cnt++;
      @(negedge clock);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    logic        exc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat;
    int we_cnt;
    int rdy_cnt;

    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;

    vecs[0] = '{32'h0000_0003, 32'h0000_0004, 64'h0000_0000_0000_000C, 1'b0};
    vecs[1] = '{32'hFFFF_FFF9, 32'h0000_0006, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0};
    vecs[2] = '{32'h0000_0006, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0};
    vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0002, 64'h0000_0000_FFFF_FFFE, 1'b1};
    vecs[4] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1};
    vecs[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1};
    vecs[6] = '{32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, 1'b0};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_product_word", product_word, 65'd0);
    check_eq("rst_we",           product_we, 1'b0);
    check_eq("rst_result",       data_result, 32'd0);
    check_eq("rst_exc",          data_exception, 1'b0);
    check_eq("rst_rdy",          data_resultRDY, 1'b0);
    check_eq("rst_busy",         busy, 1'b0);

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b);
      check_eq($sformatf("v%0d_busy", i), busy, 1'b1);
      wait_result(lat, we_cnt);
      check_eq($sformatf("v%0d_latency", i), lat, 17);
      check_eq($sformatf("v%0d_we_cycles", i), we_cnt, 17);
      check_eq($sformatf("v%0d_result", i), data_result, vecs[i].prod[31:0]);
      check_eq($sformatf("v%0d_exc", i), data_exception, vecs[i].exc);
      // Final guard bit is the multiplier's sign bit after 16 double shifts.
      check_eq($sformatf("v%0d_product_word", i), product_word, {vecs[i].prod, vecs[i].b[31]});
      check_eq($sformatf("v%0d_we_done", i), product_we, 1'b0);
      @(negedge clock);
      check_eq($sformatf("v%0d_rdy_pulse", i), data_resultRDY, 1'b0);
      check_eq($sformatf("v%0d_result_hold", i), data_result, vecs[i].prod[31:0]);
    end

    // Abort: restart with 9x9 partway through 5x5.
    start_op(32'd5, 32'd5);
    repeat (8) @(negedge clock);
    start_op(32'd9, 32'd9);
    wait_result(lat, we_cnt);
    check_eq("abort_latency", lat, 17);
    check_eq("abort_result", data_result, 32'd81);
    rdy_cnt = 0;
    repeat (25) begin
      @(negedge clock);
      if (data_resultRDY) rdy_cnt++;
    end
    check_eq("abort_extra_rdy", rdy_cnt, 0);

    // Reset in the middle of an operation.
    start_op(32'd123, 32'd456);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_eq("midrst_product_word", product_word, 65'd0);
    check_eq("midrst_we",           product_we, 1'b0);
    check_eq("midrst_result",       data_result, 32'd0);
    check_eq("midrst_exc",          data_exception, 1'b0);
    check_eq("midrst_busy",         busy, 1'b0);
    rdy_cnt = (data_resultRDY) ? 1 : 0;
    repeat (25) begin
      @(negedge clock);
      if (data_resultRDY) rdy_cnt++;
    end
    check_eq("midrst_no_rdy", rdy_cnt, 0);

    start_op(32'd2, 32'd3);
    wait_result(lat, we_cnt);
    check_eq("post_rst_latency", lat, 17);
    check_eq("post_rst_result", data_result, 32'd6);
    check_eq("post_rst_exc", data_exception, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
